ppu_scanline_buffer: RTL and testbench

Double-buffered scanline store between the PPU background renderer and the VGA scan-out. It issues per-line render requests, captures the renderer's 5-bit palette addresses into one 256-entry bank while the other bank is scanned out at 2x scale (512x480 inside 640x480). Each stored pixel is resolved through a 32-entry palette RAM into a 6-bit NES colour index for the colour-to-RGB stage.

---
 rtl/ppu_scanline_buffer.sv | 143 ++++++++++++++
 tb/tb_ppu_scanline_buffer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_scanline_buffer.sv
// Double-buffered NES scanline store: fills one 256-pixel bank from the renderer while the
// other bank is scanned out at 2x into a 512x480 window, resolved through a 32-entry palette.
module ppu_scanline_buffer (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] pixel,
   input  logic       pixel_valid,
   output logic       render,
   output logic [7:0] y_idx,
   input  logic       frame_start,
   input  logic       line_start,
   input  logic [9:0] vga_x,
   input  logic [9:0] vga_y,
   input  logic       pal_we,
   input  logic [4:0] pal_addr,
   input  logic [5:0] pal_data,
   output logic [5:0] color_idx,
   output logic       color_valid,
   output logic       underrun,
   output logic [1:0] fill_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      FILL    = 2'd2,
      FULL    = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic       wr_sel, wr_sel_nxt;
   logic [7:0] wr_ptr, wr_ptr_nxt;
   logic [7:0] y_idx_nxt;
   logic       render_nxt;
   logic       underrun_nxt;
   logic       bank_we;
   logic       swap;
   logic [7:0] swap_line;

   logic [4:0] bank [0:511];
   logic [5:0] pal  [0:31];
   logic [4:0] rd_pix;
   logic       win_q;
   logic       in_win;
   logic [4:0] pal_waddr;
   logic [4:0] lut_addr;

   assign fill_state = state;

   // Only even VGA rows swap; frame_start has priority over a coincident line_start.
   assign swap      = line_start && !frame_start && (vga_y < 10'd480) && !vga_y[0];
   assign swap_line = vga_y[8:1];

   // pixel_valid is a pure strobe with no back-pressure: each strobe in FILL is consumed.
   always_comb begin
      state_nxt    = state;
      wr_sel_nxt   = wr_sel;
      wr_ptr_nxt   = wr_ptr;
      y_idx_nxt    = y_idx;
      render_nxt   = 1'b0;
      underrun_nxt = underrun;
      bank_we      = 1'b0;
      if (frame_start) begin
         y_idx_nxt  = 8'd0;
         wr_ptr_nxt = 8'd0;
         state_nxt  = REQUEST;
      end else if (swap) begin
         wr_sel_nxt = !wr_sel;
         if (state == REQUEST || state == FILL)
            underrun_nxt = 1'b1;
         if (swap_line < 8'd239) begin
            y_idx_nxt = swap_line + 8'd1;
            state_nxt = REQUEST;
         end else begin
            state_nxt = IDLE;
         end
      end else begin
         case (state)
            REQUEST: begin
               render_nxt = 1'b1;
               wr_ptr_nxt = 8'd0;
               state_nxt  = FILL;
            end
            FILL: begin
               if (pixel_valid) begin
                  bank_we    = 1'b1;
                  wr_ptr_nxt = wr_ptr + 8'd1;
                  if (wr_ptr == 8'hFF)
                     state_nxt = FULL;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         wr_sel   <= 1'b0;
         wr_ptr   <= 8'd0;
         y_idx    <= 8'd0;
         render   <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state    <= state_nxt;
         wr_sel   <= wr_sel_nxt;
         wr_ptr   <= wr_ptr_nxt;
         y_idx    <= y_idx_nxt;
         render   <= render_nxt;
         underrun <= underrun_nxt;
      end
   end

   assign in_win = (vga_x < 10'd512) && (vga_y < 10'd480);

   // Bank storage is intentionally not reset; stale entries are visible after an underrun.
   always_ff @(posedge clk) begin
      if (bank_we)
         bank[{wr_sel, wr_ptr}] <= pixel;
      rd_pix <= bank[{!wr_sel, vga_x[8:1]}];
   end

   assign pal_waddr = (pal_addr[4] && pal_addr[1:0] == 2'b00) ? {1'b0, pal_addr[3:0]} : pal_addr;
   assign lut_addr  = (rd_pix[1:0] == 2'b00) ? 5'd0 : rd_pix;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++)
            pal[i] <= 6'd0;
         win_q       <= 1'b0;
         color_idx   <= 6'd0;
         color_valid <= 1'b0;
      end else begin
         if (pal_we)
            pal[pal_waddr] <= pal_data;
         win_q       <= in_win;
         color_valid <= win_q;
         color_idx   <= win_q ? pal[lut_addr] : 6'h0F;
      end
   end

endmodule

// File: tb/tb_ppu_scanline_buffer.sv
// Directed bench for ppu_scanline_buffer: fill/swap/replay, palette mirror, underrun,
// window edges, frame_start collisions and reset during a fill.
module tb_ppu_scanline_buffer;

   logic       clk;
   logic       reset;
   logic [4:0] pixel;
   logic       pixel_valid;
   logic       render;
   logic [7:0] y_idx;
   logic       frame_start;
   logic       line_start;
   logic [9:0] vga_x;
   logic [9:0] vga_y;
   logic       pal_we;
   logic [4:0] pal_addr;
   logic [5:0] pal_data;
   logic [5:0] color_idx;
   logic       color_valid;
   logic       underrun;
   logic [1:0] fill_state;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd2;
   localparam logic [1:0] ST_FULL = 2'd3;

   int tests_run = 0;
   int tests_failed = 0;
   logic [5:0] pal_m [0:31];

   ppu_scanline_buffer dut (
      .clk(clk), .reset(reset), .pixel(pixel), .pixel_valid(pixel_valid),
      .render(render), .y_idx(y_idx), .frame_start(frame_start), .line_start(line_start),
      .vga_x(vga_x), .vga_y(vga_y), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
      .color_idx(color_idx), .color_valid(color_valid), .underrun(underrun),
      .fill_state(fill_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] pat_a(input int i);
      logic [7:0] v;
      v = 8'(i);
      return v[4:0];
   endfunction

   function automatic logic [4:0] pat_b(input int i);
      logic [7:0] v;
      v = ~8'(i);
      return v[4:0];
   endfunction

   function automatic logic [5:0] exp_color(input logic [4:0] p);
      return (p[1:0] == 2'b00) ? pal_m[0] : pal_m[p];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
      pal_we = 1'b1; pal_addr = a; pal_data = d;
      tick();
      pal_we = 1'b0;
      if (a[4] && a[1:0] == 2'b00) pal_m[{1'b0, a[3:0]}] = d;
      else pal_m[a] = d;
   endtask

   // mode 0: pat_a, 1: pat_b, 2: constant 1, 3: constant 0x1F
   task automatic fill(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         pixel_valid = 1'b1;
         case (mode)
            0: pixel = pat_a(i);
            1: pixel = pat_b(i);
            2: pixel = 5'd1;
            default: pixel = 5'h1F;
         endcase
         tick();
      end
      pixel_valid = 1'b0;
   endtask

   task automatic line(input logic [9:0] y);
      line_start = 1'b1; vga_y = y;
      tick();
      line_start = 1'b0;
   endtask

   task automatic scan(input logic [9:0] x, input logic [9:0] y,
                       output logic [5:0] c, output logic v);
      vga_x = x; vga_y = y;
      tick();
      tick();
      c = color_idx; v = color_valid;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      tests_run++;
      if ({render, y_idx, color_idx, color_valid, underrun, fill_state} !== {1'b0, 8'd0, 6'd0, 1'b0, 1'b0, ST_IDLE}) begin
         tests_failed++;
         $display("FAIL reset_state: render=%b y=%0d color=%h valid=%b underrun=%b state=%0d, required all zero",
                  render, y_idx, color_idx, color_valid, underrun, fill_state);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 32; i++) pal_write(5'(i), 6'(i + 32));
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tests_run++;
      if (render !== 1'b0) begin
         tests_failed++;
         $display("FAIL render_early: render=%b required 0 while in REQUEST", render);
      end
      tick();
      tests_run++;
      if (render !== 1'b1 || y_idx !== 8'd0 || fill_state !== ST_FILL) begin
         tests_failed++;
         $display("FAIL render_pulse: render=%b y=%0d state=%0d required 1/0/%0d", render, y_idx, fill_state, ST_FILL);
      end
      fill(256, 0);
      tests_run++;
      if (render !== 1'b0 || fill_state !== ST_FULL) begin
         tests_failed++;
         $display("FAIL fill_full: render=%b state=%0d required 0/%0d", render, fill_state, ST_FULL);
      end
      fill(4, 3);
      tests_run++;
      if (fill_state !== ST_FULL) begin
         tests_failed++;
         $display("FAIL full_hold: state=%0d required %0d", fill_state, ST_FULL);
      end
   endtask

   task automatic test_swap_scan();
      int idx [8] = '{0, 1, 2, 3, 4, 5, 37, 255};
      logic [5:0] c;
      logic v;
      line(10'd0);
      tick();
      tests_run++;
      if (render !== 1'b1 || y_idx !== 8'd1) begin
         tests_failed++;
         $display("FAIL swap_request: render=%b y=%0d required 1/1", render, y_idx);
      end
      tick();
      tests_run++;
      if (render !== 1'b0) begin
         tests_failed++;
         $display("FAIL render_one_cycle: render=%b required 0", render);
      end
      foreach (idx[k]) begin
         scan(10'(2 * idx[k] + (k % 2)), 10'd0, c, v);
         tests_run++;
         if (c !== exp_color(pat_a(idx[k])) || v !== 1'b1) begin
            tests_failed++;
            $display("FAIL scan_line0 x=%0d: color=%h valid=%b required %h/1",
                     2 * idx[k] + (k % 2), c, v, exp_color(pat_a(idx[k])));
         end
      end
   endtask

   task automatic test_replay();
      logic [5:0] c;
      logic v;
      line(10'd1);
      tick();
      tests_run++;
      if (render !== 1'b0 || fill_state !== ST_FILL || y_idx !== 8'd1) begin
         tests_failed++;
         $display("FAIL replay_no_request: render=%b state=%0d y=%0d required 0/%0d/1", render, fill_state, y_idx, ST_FILL);
      end
      for (int i = 6; i < 8; i++) begin
         scan(10'(2 * i), 10'd1, c, v);
         tests_run++;
         if (c !== exp_color(pat_a(i)) || v !== 1'b1) begin
            tests_failed++;
            $display("FAIL replay_color i=%0d: color=%h valid=%b required %h/1", i, c, v, exp_color(pat_a(i)));
         end
      end
   endtask

   task automatic test_window();
      logic [5:0] c;
      logic v;
      scan(10'd512, 10'd1, c, v);
      tests_run++;
      if (c !== 6'h0F || v !== 1'b0) begin
         tests_failed++;
         $display("FAIL window_x512: color=%h valid=%b required 0f/0", c, v);
      end
      scan(10'd511, 10'd1, c, v);
      tests_run++;
      if (c !== exp_color(pat_a(255)) || v !== 1'b1) begin
         tests_failed++;
         $display("FAIL window_x511: color=%h valid=%b required %h/1", c, v, exp_color(pat_a(255)));
      end
      scan(10'd0, 10'd480, c, v);
      tests_run++;
      if (c !== 6'h0F || v !== 1'b0) begin
         tests_failed++;
         $display("FAIL window_y480: color=%h valid=%b required 0f/0", c, v);
      end
   endtask

   task automatic test_palette_mirror();
      logic [5:0] old_c;
      old_c = pal_m[0];
      vga_x = 10'd0; vga_y = 10'd0;
      tick();
      pal_write(5'h10, 6'h2A);
      tests_run++;
      if (color_idx !== old_c) begin
         tests_failed++;
         $display("FAIL pal_same_cycle: color=%h required old %h", color_idx, old_c);
      end
      tick();
      tests_run++;
      if (color_idx !== 6'h2A) begin
         tests_failed++;
         $display("FAIL pal_mirror: color=%h required 2a", color_idx);
      end
   endtask

   task automatic test_underrun();
      int idx [3] = '{50, 100, 200};
      logic [5:0] c, e;
      logic v;
      fill(256, 1);
      line(10'd2);
      tick();
      tests_run++;
      if (underrun !== 1'b0 || y_idx !== 8'd2 || render !== 1'b1) begin
         tests_failed++;
         $display("FAIL swap_full_ok: underrun=%b y=%0d render=%b required 0/2/1", underrun, y_idx, render);
      end
      fill(256, 0);
      line(10'd4);
      tick();
      fill(100, 2);
      line_start = 1'b1; vga_y = 10'd6; pixel_valid = 1'b1; pixel = 5'd1;
      tick();
      line_start = 1'b0; pixel_valid = 1'b0;
      tests_run++;
      if (underrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL underrun_set: underrun=%b required 1", underrun);
      end
      tick();
      tests_run++;
      if (y_idx !== 8'd4) begin
         tests_failed++;
         $display("FAIL underrun_request: y=%0d required 4", y_idx);
      end
      foreach (idx[k]) begin
         e = (idx[k] < 100) ? exp_color(5'd1) : exp_color(pat_b(idx[k]));
         scan(10'(2 * idx[k]), 10'd6, c, v);
         tests_run++;
         if (c !== e) begin
            tests_failed++;
            $display("FAIL underrun_stale i=%0d: color=%h required %h", idx[k], c, e);
         end
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tests_run++;
      if (underrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL underrun_sticky: underrun=%b required 1", underrun);
      end
      tick();
   endtask

   task automatic test_collision();
      logic [5:0] c;
      logic v;
      frame_start = 1'b1; line_start = 1'b1; vga_y = 10'd12;
      tick();
      frame_start = 1'b0; line_start = 1'b0;
      tick();
      tests_run++;
      if (render !== 1'b1 || y_idx !== 8'd0) begin
         tests_failed++;
         $display("FAIL collision_request: render=%b y=%0d required 1/0", render, y_idx);
      end
      scan(10'd100, 10'd12, c, v);
      tests_run++;
      if (c !== exp_color(5'd1)) begin
         tests_failed++;
         $display("FAIL collision_no_swap: color=%h required %h", c, exp_color(5'd1));
      end
   endtask

   task automatic test_last_line();
      line(10'd476);
      tick();
      tests_run++;
      if (y_idx !== 8'd239 || render !== 1'b1) begin
         tests_failed++;
         $display("FAIL line_239_request: y=%0d render=%b required 239/1", y_idx, render);
      end
      line(10'd478);
      tests_run++;
      if (fill_state !== ST_IDLE || y_idx !== 8'd239) begin
         tests_failed++;
         $display("FAIL last_swap_idle: state=%0d y=%0d required %0d/239", fill_state, y_idx, ST_IDLE);
      end
      tick();
      tests_run++;
      if (render !== 1'b0) begin
         tests_failed++;
         $display("FAIL last_swap_no_render: render=%b required 0", render);
      end
   endtask

   task automatic test_reset_midfill();
      int pulses = 0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      fill(10, 0);
      vga_x = 10'd4; vga_y = 10'd0;
      reset = 1'b1;
      #1;
      tests_run++;
      if ({render, y_idx, color_idx, color_valid, underrun, fill_state} !== {1'b0, 8'd0, 6'd0, 1'b0, 1'b0, ST_IDLE}) begin
         tests_failed++;
         $display("FAIL reset_midfill: render=%b y=%0d color=%h valid=%b underrun=%b state=%0d, required all zero",
                  render, y_idx, color_idx, color_valid, underrun, fill_state);
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (render) pulses++;
      end
      tests_run++;
      if (pulses != 0 || fill_state !== ST_IDLE) begin
         tests_failed++;
         $display("FAIL reset_no_request: render pulses=%0d state=%0d required 0/%0d", pulses, fill_state, ST_IDLE);
      end
   endtask

   initial begin
      reset = 1'b1; pixel = '0; pixel_valid = 1'b0; frame_start = 1'b0; line_start = 1'b0;
      vga_x = '0; vga_y = '0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
      for (int i = 0; i < 32; i++) pal_m[i] = 6'd0;
      test_reset();
      test_fill();
      test_swap_scan();
      test_replay();
      test_window();
      test_palette_mirror();
      test_underrun();
      test_collision();
      test_last_line();
      test_reset_midfill();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
